// File: rtl/pulpino_pad_pkg.sv
// Shared constants and helpers for the pad-side GPIO input path.
// Defaults and threshold clamping used by the debounce cells.
package pulpino_pad_pkg;

   localparam int GPIO_SYNC_STAGES_DEFAULT = 2;
   localparam int GPIO_DEB_CNT_WIDTH       = 16;

   // A programmed threshold of zero behaves like one.
   function automatic logic [31:0] thr_clamp(input logic [31:0] thr);
      return (thr == 32'd0) ? 32'd1 : thr;
   endfunction

endpackage

// File: rtl/gpio_debounce_cell.sv
// One conditioned GPIO bit: synchroniser, debounce counter,
// committed level flop and registered rise/fall event flops.
module gpio_debounce_cell
   import pulpino_pad_pkg::*;
#(
   parameter int   SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT,
   parameter int   CNT_WIDTH   = GPIO_DEB_CNT_WIDTH,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pad,
   input  logic                 deb_en,
   input  logic [CNT_WIDTH-1:0] thresh,
   output logic                 level,
   output logic                 rise,
   output logic                 fall,
   output logic                 evt_next
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_next;
   logic                   stable_q;
   logic                   stable_next;
   logic                   rise_q;
   logic                   fall_q;
   logic                   s;
   logic [31:0]            thr;
   logic [31:0]            cnt_inc;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      end
   end

   // Conditions overlap, so the first matching arm wins.
   always_comb begin
      thr         = thr_clamp(32'(thresh));
      cnt_inc     = 32'(cnt_q) + 32'd1;
      stable_next = stable_q;
      cnt_next    = '0;
      priority case (1'b1)
         !deb_en:        stable_next = s;
         s == stable_q:  cnt_next    = '0;
         cnt_inc >= thr: stable_next = s;
         default:        cnt_next    = cnt_inc[CNT_WIDTH-1:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         stable_q <= RESET_VAL;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_next;
         stable_q <= stable_next;
         rise_q   <= stable_next & ~stable_q;
         fall_q   <= ~stable_next & stable_q;
      end
   end

   assign level    = stable_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign evt_next = stable_next ^ stable_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Pad input conditioner: per-bit sync/debounce cells plus a
// registered summary event flag aligned with the edge pulses.
module gpio_in_conditioner
   import pulpino_pad_pkg::*;
#(
   parameter int                 NB_GPIO     = 32,
   parameter int                 SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT,
   parameter int                 CNT_WIDTH   = GPIO_DEB_CNT_WIDTH,
   parameter logic [NB_GPIO-1:0] RESET_VAL   = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NB_GPIO-1:0]   gpio_pad_i,
   input  logic [NB_GPIO-1:0]   cfg_deb_en_i,
   input  logic [CNT_WIDTH-1:0] cfg_thresh_i,
   output logic [NB_GPIO-1:0]   gpio_in_o,
   output logic [NB_GPIO-1:0]   gpio_rise_o,
   output logic [NB_GPIO-1:0]   gpio_fall_o,
   output logic                 gpio_evt_o
);

   logic [NB_GPIO-1:0] evt_next;
   logic               evt_q;

   for (genvar i = 0; i < NB_GPIO; i++) begin : g_bit
      gpio_debounce_cell #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_WIDTH   (CNT_WIDTH),
         .RESET_VAL   (RESET_VAL[i])
      ) u_cell (
         .clk      (clk),
         .rst_n    (rst_n),
         .pad      (gpio_pad_i[i]),
         .deb_en   (cfg_deb_en_i[i]),
         .thresh   (cfg_thresh_i),
         .level    (gpio_in_o[i]),
         .rise     (gpio_rise_o[i]),
         .fall     (gpio_fall_o[i]),
         .evt_next (evt_next[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q <= 1'b0;
      end else begin
         evt_q <= |evt_next;
      end
   end

   assign gpio_evt_o = evt_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed and random checks of gpio_in_conditioner against a
// cycle-level reference model of the sync + debounce rules.
module tb_gpio_in_conditioner;

   localparam int NB = 8;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic [NB-1:0] pad;
   logic [NB-1:0] deb_en;
   logic [CW-1:0] thresh;
   logic [NB-1:0] gpio_in;
   logic [NB-1:0] rise;
   logic [NB-1:0] fall;
   logic          evt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [NB-1:0] m_sync0, m_sync1, m_level, m_rise, m_fall;
   logic          m_evt;
   int            m_age [NB];

   gpio_in_conditioner #(
      .NB_GPIO     (NB),
      .SYNC_STAGES (2),
      .CNT_WIDTH   (CW),
      .RESET_VAL   ('0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .gpio_pad_i   (pad),
      .cfg_deb_en_i (deb_en),
      .cfg_thresh_i (thresh),
      .gpio_in_o    (gpio_in),
      .gpio_rise_o  (rise),
      .gpio_fall_o  (fall),
      .gpio_evt_o   (evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_sync0 = '0;
      m_sync1 = '0;
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_evt   = 1'b0;
      for (int i = 0; i < NB; i++) m_age[i] = 0;
   endtask

   task automatic chk_vec(input string tag, input logic [NB-1:0] got,
                          input logic [NB-1:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic chk_bit(input string tag, input logic got, input logic want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got=%b want=%b", tag, got, want);
      end
   endtask

   task automatic chk_all(input string tag);
      chk_vec({tag, ".level"}, gpio_in, m_level);
      chk_vec({tag, ".rise"}, rise, m_rise);
      chk_vec({tag, ".fall"}, fall, m_fall);
      chk_bit({tag, ".evt"}, evt, m_evt);
   endtask

   // A bit commits when bypassed, or once the synchronised pad has
   // disagreed with the committed level for thr enabled cycles in a row.
   task automatic tick(input string tag);
      logic [NB-1:0] s;
      logic [NB-1:0] nxt;
      int            thr;
      s   = m_sync1;
      nxt = m_level;
      thr = (thresh == 0) ? 1 : int'(thresh);
      for (int i = 0; i < NB; i++) begin
         if (deb_en[i] && s[i] != m_level[i]) m_age[i] = m_age[i] + 1;
         else m_age[i] = 0;
         if (!deb_en[i] || m_age[i] >= thr) begin
            nxt[i]   = s[i];
            m_age[i] = 0;
         end
      end
      @(posedge clk);
      if (rst_n) begin
         m_rise  = nxt & ~m_level;
         m_fall  = ~nxt & m_level;
         m_evt   = (nxt != m_level);
         m_level = nxt;
         m_sync1 = m_sync0;
         m_sync0 = pad;
      end else begin
         model_reset();
      end
      #1;
      chk_all(tag);
   endtask

   task automatic ticks(input string tag, input int n);
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   initial begin
      rst_n  = 1'b0;
      pad    = '0;
      deb_en = '0;
      thresh = '0;
      model_reset();
      #12;
      chk_all("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ticks("idle", 3);

      // Bypass: visible three edges after the pad change
      pad[0] = 1'b1;
      ticks("byp", 3);
      chk_bit("byp.level3", gpio_in[0], 1'b1);
      chk_bit("byp.rise3", rise[0], 1'b1);
      tick("byp");
      chk_bit("byp.rise4", rise[0], 1'b0);

      // Debounce thr=4
      deb_en[5] = 1'b1;
      thresh    = 4'd4;
      pad[5]    = 1'b1;
      ticks("deb", 5);
      chk_bit("deb.level5", gpio_in[5], 1'b0);
      tick("deb");
      chk_bit("deb.level6", gpio_in[5], 1'b1);
      chk_bit("deb.rise6", rise[5], 1'b1);
      chk_bit("deb.evt6", evt, 1'b1);
      tick("deb");
      chk_bit("deb.evt7", evt, 1'b0);

      // Glitch of three cycles is discarded
      pad[5] = 1'b0;
      ticks("glitch", 3);
      pad[5] = 1'b1;
      ticks("glitch", 8);
      chk_bit("glitch.level", gpio_in[5], 1'b1);

      // Threshold 0 behaves like bypass
      deb_en[7] = 1'b1;
      thresh    = 4'd0;
      pad[7]    = 1'b1;
      ticks("thr0", 3);
      chk_bit("thr0.rise", rise[7], 1'b1);
      pad[7] = 1'b0;
      ticks("thr0", 3);
      chk_bit("thr0.fall", fall[7], 1'b1);
      chk_bit("thr0.level", gpio_in[7], 1'b0);

      // Threshold lowered mid-count
      deb_en[2] = 1'b1;
      thresh    = 4'd10;
      pad[2]    = 1'b1;
      ticks("midthr", 7);
      chk_bit("midthr.hold", gpio_in[2], 1'b0);
      thresh = 4'd3;
      tick("midthr");
      chk_bit("midthr.commit", gpio_in[2], 1'b1);
      chk_bit("midthr.rise", rise[2], 1'b1);

      // Debounce disabled mid-count
      deb_en[3] = 1'b1;
      thresh    = 4'd10;
      pad[3]    = 1'b1;
      ticks("midden", 4);
      chk_bit("midden.hold", gpio_in[3], 1'b0);
      deb_en[3] = 1'b0;
      tick("midden");
      chk_bit("midden.commit", gpio_in[3], 1'b1);

      // Maximum threshold
      deb_en[1] = 1'b1;
      thresh    = 4'd15;
      pad[1]    = 1'b1;
      ticks("max", 16);
      chk_bit("max.hold", gpio_in[1], 1'b0);
      tick("max");
      chk_bit("max.commit", gpio_in[1], 1'b1);

      // Reset during a pending commit
      deb_en[6] = 1'b1;
      thresh    = 4'd8;
      pad[6]    = 1'b1;
      ticks("rst", 6);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_all("rst.async");
      ticks("rst.hold", 2);
      rst_n = 1'b1;
      ticks("rst.rel", 9);
      chk_bit("rst.pend", gpio_in[6], 1'b0);
      tick("rst.rel");
      chk_bit("rst.commit", gpio_in[6], 1'b1);
      chk_bit("rst.rise", rise[6], 1'b1);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         if (c % 50 == 0) begin
            deb_en = NB'($urandom);
            thresh = CW'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 3) == 0) pad[$urandom_range(0, NB - 1)] ^= 1'b1;
         if ($urandom_range(0, 99) == 0) thresh = CW'($urandom_range(0, 15));
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
